// File: rtl/syncram_fifo_ctrl.sv
// FIFO controller wrapped around a dual-port synchronous RAM (port A write, port B read).
// Keeps registered pointers, word count and flags, and produces a read-valid strobe for the RAM's 1-cycle read latency.
module syncram_fifo_ctrl #(
  parameter int width             = 8,
  parameter int widthad           = 4,
  parameter int almost_full_value = 12
) (
  input  logic               clock0,
  input  logic               sclr,
  input  logic               wrreq,
  input  logic [width-1:0]   data,
  input  logic               rdreq,
  output logic [width-1:0]   q,
  output logic               rdvalid,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic [widthad:0]   usedw,
  output logic               overflow,
  output logic               underflow,
  output logic [widthad-1:0] ram_address_a,
  output logic               ram_wren_a,
  output logic [width-1:0]   ram_data_a,
  output logic [widthad-1:0] ram_address_b,
  output logic               ram_rden_b,
  input  logic [width-1:0]   ram_q_b
);

  localparam logic [widthad:0] DEPTH_W = (widthad+1)'(2**widthad);
  localparam logic [widthad:0] AF_W    = (widthad+1)'(almost_full_value);

  logic [widthad-1:0] r_wr_ptr;
  logic [widthad-1:0] r_rd_ptr;
  logic [widthad:0]   r_usedw;
  logic               r_full;
  logic               r_empty;
  logic               r_almost_full;
  logic               r_rdvalid;
  logic               r_overflow;
  logic               r_underflow;

  logic               w_wr_acc;
  logic               w_rd_acc;
  logic [widthad:0]   w_usedw_nxt;

  // Handshake: wrreq/rdreq act as valid; the implicit ready is ~full / ~empty
  // taken from registered flags, so a request is accepted exactly when valid
  // and ready are both high at a rising edge; rejected requests have no effect
  // other than setting the sticky overflow/underflow bit.
  assign w_wr_acc    = wrreq & ~r_full;
  assign w_rd_acc    = rdreq & ~r_empty;
  assign w_usedw_nxt = r_usedw + (widthad+1)'(w_wr_acc) - (widthad+1)'(w_rd_acc);

  always_ff @(posedge clock0) begin
    if (sclr) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_usedw       <= '0;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_almost_full <= 1'b0;
      r_rdvalid     <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_usedw       <= w_usedw_nxt;
      r_full        <= (w_usedw_nxt == DEPTH_W);
      r_empty       <= (w_usedw_nxt == '0);
      r_almost_full <= (w_usedw_nxt >= AF_W);
      r_rdvalid     <= w_rd_acc;
      if (wrreq & r_full)  r_overflow  <= 1'b1;
      if (rdreq & r_empty) r_underflow <= 1'b1;
    end
  end

  // RAM port drive: pointers address the RAM directly, data passes straight through.
  assign ram_address_a = r_wr_ptr;
  assign ram_wren_a    = w_wr_acc;
  assign ram_data_a    = data;
  assign ram_address_b = r_rd_ptr;
  assign ram_rden_b    = w_rd_acc;

  assign q           = ram_q_b;
  assign rdvalid     = r_rdvalid;
  assign full        = r_full;
  assign empty       = r_empty;
  assign almost_full = r_almost_full;
  assign usedw       = r_usedw;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule
